// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_pkg
// Description : Shared definitions for the matrix processing unit sequencer:
//               instruction opcodes, ALU select codes, FSM state encoding and
//               a constant-evaluable ceiling-log2 helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_pkg;

    // Host instruction opcodes (instr[3:0])
    localparam logic [3:0] c_op_nop    = 4'b0000;
    localparam logic [3:0] c_op_load   = 4'b0100;
    localparam logic [3:0] c_op_copy   = 4'b0101;
    localparam logic [3:0] c_op_unload = 4'b0110;
    localparam logic [3:0] c_op_clear  = 4'b0111;
    localparam logic [3:0] c_op_add    = 4'b1100;
    localparam logic [3:0] c_op_shift  = 4'b1101;
    localparam logic [3:0] c_op_sub    = 4'b1110;
    localparam logic [3:0] c_op_mult   = 4'b1111;

    // ALU output select codes
    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_shift = 2'b01;
    localparam logic [1:0] c_alu_sub   = 2'b10;
    localparam logic [1:0] c_alu_mult  = 2'b11;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_COPY   = 3'd4,
        ST_CLEAR  = 3'd5,
        ST_EXEC   = 3'd6
    } mpu_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_xfer_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mpu_xfer_cnt
// Description : Beat counter and bit-offset generator for host transfers.
//               The counter is one bit wider than needed for BEATS-1 so that
//               it can reach BEATS without wrapping inside an operation.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               clr_i        - synchronous clear (takes priority over inc_i)
//               inc_i        - advance by one beat
//               offset_o     - bit offset of the current beat
//               last_o       - current beat is the final one (BEATS-1)
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_xfer_cnt
    import mpu_pkg::*;
#(
    parameter  int BEATS     = 64,
    parameter  int XFER_BITS = 8,
    parameter  int OFF_W     = 9,
    localparam int CNT_W     = clog2(BEATS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [OFF_W-1:0] offset_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign offset_o = OFF_W'(cnt_q) * OFF_W'(XFER_BITS);
    assign last_o   = (cnt_q == CNT_W'(BEATS - 1));

endmodule
`default_nettype wire

// File: rtl/mpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mpu_ctrl_fsm
// Description : Instruction sequencer for the matrix processing unit. Accepts
//               host instructions over valid/ready, latches operands and
//               drives BRAM bank strobes, bank selects, ALU select and the
//               host transfer offset, with beat-level flow control.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               instr_i           - {dst, src, opcode[3:0]}
//               instr_valid_i     - instruction presented
//               instr_ready_o     - high only in IDLE
//               busy_o            - not IDLE
//               err_o             - one-cycle pulse after an invalid opcode
//               done_o            - final active cycle of an operation
//               src_sel_o/dst_sel_o - latched source/destination bank
//               alu_sel_o         - 00 add, 01 shift, 10 sub, 11 mult
//               bram_in_sel_o     - BRAM-to-BRAM write data (COPY)
//               bank_we_o/bank_be_o/bank_clr_o - row write, beat write, clear
//               offset_o          - bit offset of the current beat
//               beat_in_valid_i   - host write beat valid (LOAD)
//               beat_out_valid_o  - read beat valid (UNLOAD)
//               beat_out_ready_i  - host accepts read beat
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_ctrl_fsm
    import mpu_pkg::*;
#(
    parameter  int NUM_BANKS = 4,
    parameter  int DATA_BITS = 512,
    parameter  int XFER_BITS = 8,
    parameter  int OP_LAT    = 1,
    localparam int BANK_W    = clog2(NUM_BANKS),
    localparam int BEATS     = DATA_BITS / XFER_BITS,
    localparam int OFF_W     = clog2(DATA_BITS),
    localparam int INSTR_W   = 4 + 2 * BANK_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 done_o,
    output logic [BANK_W-1:0]    src_sel_o,
    output logic [BANK_W-1:0]    dst_sel_o,
    output logic [1:0]           alu_sel_o,
    output logic                 bram_in_sel_o,
    output logic [NUM_BANKS-1:0] bank_we_o,
    output logic [NUM_BANKS-1:0] bank_be_o,
    output logic [NUM_BANKS-1:0] bank_clr_o,
    output logic [OFF_W-1:0]     offset_o,
    input  logic                 beat_in_valid_i,
    output logic                 beat_out_valid_o,
    input  logic                 beat_out_ready_i
);

    localparam int EXEC_W = clog2(OP_LAT) + 1;

    mpu_state_e          state_q;
    logic [BANK_W-1:0]   src_q;
    logic [BANK_W-1:0]   dst_q;
    logic [1:0]          alu_sel_q;
    logic                err_q;
    logic [EXEC_W-1:0]   exec_cnt_q;

    logic [3:0]          w_op;
    logic [BANK_W-1:0]   w_src;
    logic [BANK_W-1:0]   w_dst;
    logic [NUM_BANKS-1:0] w_dst_oh;
    logic                w_inc;
    logic                w_clr;
    logic                w_last;
    logic                w_exec_last;
    logic [OFF_W-1:0]    w_offset;

    assign w_op        = instr_i[3:0];
    assign w_src       = instr_i[4 +: BANK_W];
    assign w_dst       = instr_i[4 + BANK_W +: BANK_W];
    assign w_dst_oh    = NUM_BANKS'(1) << dst_q;
    assign w_exec_last = (exec_cnt_q == EXEC_W'(OP_LAT - 1));

    // Beat counter is held cleared while idle so every LOAD/UNLOAD starts at 0.
    assign w_clr = (state_q == ST_IDLE);

    mpu_xfer_cnt #(
        .BEATS     (BEATS),
        .XFER_BITS (XFER_BITS),
        .OFF_W     (OFF_W)
    ) u_xfer_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (w_clr),
        .inc_i    (w_inc),
        .offset_o (w_offset),
        .last_o   (w_last)
    );

    // ------------------------------------------------------------------------
    // Sequencer state and latched operands
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            src_q      <= '0;
            dst_q      <= '0;
            alu_sel_q  <= c_alu_add;
            err_q      <= 1'b0;
            exec_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_RESET: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        src_q      <= w_src;
                        dst_q      <= w_dst;
                        exec_cnt_q <= '0;
                        case (w_op)
                            c_op_nop:    state_q <= ST_IDLE;
                            c_op_load:   state_q <= ST_LOAD;
                            c_op_unload: state_q <= ST_UNLOAD;
                            c_op_copy:   state_q <= ST_COPY;
                            c_op_clear:  state_q <= ST_CLEAR;
                            c_op_add: begin
                                state_q   <= ST_EXEC;
                                alu_sel_q <= c_alu_add;
                            end
                            c_op_shift: begin
                                state_q   <= ST_EXEC;
                                alu_sel_q <= c_alu_shift;
                            end
                            c_op_sub: begin
                                state_q   <= ST_EXEC;
                                alu_sel_q <= c_alu_sub;
                            end
                            c_op_mult: begin
                                state_q   <= ST_EXEC;
                                alu_sel_q <= c_alu_mult;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (beat_in_valid_i && w_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_UNLOAD: begin
                    if (beat_out_ready_i && w_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COPY, ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                ST_EXEC: begin
                    if (w_exec_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        exec_cnt_q <= exec_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the registered state; only the beat handshakes
    // qualify strobes combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        bank_we_o        = '0;
        bank_be_o        = '0;
        bank_clr_o       = '0;
        done_o           = 1'b0;
        bram_in_sel_o    = 1'b0;
        beat_out_valid_o = 1'b0;
        offset_o         = '0;
        w_inc            = 1'b0;
        case (state_q)
            ST_RESET: begin
                // Clear-all only once reset is released; while reset is held
                // every strobe stays low.
                bank_clr_o = reset ? '0 : '1;
            end
            ST_LOAD: begin
                bank_be_o = beat_in_valid_i ? w_dst_oh : '0;
                w_inc     = beat_in_valid_i;
                done_o    = beat_in_valid_i & w_last;
                offset_o  = w_offset;
            end
            ST_UNLOAD: begin
                beat_out_valid_o = 1'b1;
                w_inc            = beat_out_ready_i;
                done_o           = beat_out_ready_i & w_last;
                offset_o         = w_offset;
            end
            ST_COPY: begin
                bank_we_o     = w_dst_oh;
                bram_in_sel_o = 1'b1;
                done_o        = 1'b1;
            end
            ST_CLEAR: begin
                bank_clr_o = w_dst_oh;
                done_o     = 1'b1;
            end
            ST_EXEC: begin
                if (w_exec_last) begin
                    bank_we_o = w_dst_oh;
                    done_o    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign instr_ready_o = (state_q == ST_IDLE);
    assign busy_o        = ~instr_ready_o;
    assign err_o         = err_q;
    assign src_sel_o     = src_q;
    assign dst_sel_o     = dst_q;
    assign alu_sel_o     = alu_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_ctrl_fsm
// Description : Self-checking bench for mpu_ctrl_fsm. Instance A uses the
//               default geometry (4 banks, OP_LAT=1); instance B uses 8 banks
//               and OP_LAT=3. Expected values come from a transaction-level
//               model of the instruction set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_ctrl_fsm;

    localparam int BEATS = 64;
    localparam int XFER  = 8;

    localparam logic [3:0] c_nop    = 4'b0000;
    localparam logic [3:0] c_load   = 4'b0100;
    localparam logic [3:0] c_copy   = 4'b0101;
    localparam logic [3:0] c_unload = 4'b0110;
    localparam logic [3:0] c_clear  = 4'b0111;
    localparam logic [3:0] c_add    = 4'b1100;
    localparam logic [3:0] c_shift  = 4'b1101;
    localparam logic [3:0] c_sub    = 4'b1110;
    localparam logic [3:0] c_mult   = 4'b1111;

    logic clk;
    logic reset;

    logic [7:0] a_instr;
    logic       a_instr_valid, a_instr_ready, a_busy, a_err, a_done;
    logic [1:0] a_src_sel, a_dst_sel, a_alu_sel;
    logic       a_bram_in_sel;
    logic [3:0] a_bank_we, a_bank_be, a_bank_clr;
    logic [8:0] a_offset;
    logic       a_beat_in_valid, a_beat_out_valid, a_beat_out_ready;

    logic [9:0] b_instr;
    logic       b_instr_valid, b_instr_ready, b_busy, b_err, b_done;
    logic [2:0] b_src_sel, b_dst_sel;
    logic [1:0] b_alu_sel;
    logic       b_bram_in_sel;
    logic [7:0] b_bank_we, b_bank_be, b_bank_clr;
    logic [8:0] b_offset;
    logic       b_beat_in_valid, b_beat_out_valid, b_beat_out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    mpu_ctrl_fsm #(.NUM_BANKS(4), .DATA_BITS(512), .XFER_BITS(8), .OP_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset), .instr_i(a_instr), .instr_valid_i(a_instr_valid),
        .instr_ready_o(a_instr_ready), .busy_o(a_busy), .err_o(a_err), .done_o(a_done),
        .src_sel_o(a_src_sel), .dst_sel_o(a_dst_sel), .alu_sel_o(a_alu_sel),
        .bram_in_sel_o(a_bram_in_sel), .bank_we_o(a_bank_we), .bank_be_o(a_bank_be),
        .bank_clr_o(a_bank_clr), .offset_o(a_offset), .beat_in_valid_i(a_beat_in_valid),
        .beat_out_valid_o(a_beat_out_valid), .beat_out_ready_i(a_beat_out_ready)
    );

    mpu_ctrl_fsm #(.NUM_BANKS(8), .DATA_BITS(512), .XFER_BITS(8), .OP_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset), .instr_i(b_instr), .instr_valid_i(b_instr_valid),
        .instr_ready_o(b_instr_ready), .busy_o(b_busy), .err_o(b_err), .done_o(b_done),
        .src_sel_o(b_src_sel), .dst_sel_o(b_dst_sel), .alu_sel_o(b_alu_sel),
        .bram_in_sel_o(b_bram_in_sel), .bank_we_o(b_bank_we), .bank_be_o(b_bank_be),
        .bank_clr_o(b_bank_clr), .offset_o(b_offset), .beat_in_valid_i(b_beat_in_valid),
        .beat_out_valid_o(b_beat_out_valid), .beat_out_ready_i(b_beat_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ALU select code for each arithmetic opcode
    function automatic logic [1:0] exp_alu(input logic [3:0] op);
        case (op)
            c_add:   return 2'b00;
            c_shift: return 2'b01;
            c_sub:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic send_a(input logic [3:0] op, input logic [1:0] s, input logic [1:0] d);
        @(negedge clk);
        n_checks++;
        if (a_instr_ready !== 1'b1) $display("FAIL send_a_ready: got %b want 1", a_instr_ready);
        else n_pass++;
        a_instr       = {d, s, op};
        a_instr_valid = 1'b1;
        @(negedge clk);
        a_instr_valid = 1'b0;
        a_instr       = 8'($urandom);
    endtask

    task automatic send_b(input logic [3:0] op, input logic [2:0] s, input logic [2:0] d);
        @(negedge clk);
        n_checks++;
        if (b_instr_ready !== 1'b1) $display("FAIL send_b_ready: got %b want 1", b_instr_ready);
        else n_pass++;
        b_instr       = {d, s, op};
        b_instr_valid = 1'b1;
        @(negedge clk);
        b_instr_valid = 1'b0;
        b_instr       = 10'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_instr = '0; a_instr_valid = 1'b0; a_beat_in_valid = 1'b0; a_beat_out_ready = 1'b0;
        b_instr = '0; b_instr_valid = 1'b0; b_beat_in_valid = 1'b0; b_beat_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({a_bank_we, a_bank_be, a_bank_clr, a_err, a_done, a_src_sel, a_dst_sel, a_alu_sel,
             a_bram_in_sel, a_beat_out_valid, a_offset} !== 33'b0)
            $display("FAIL reset_outs_a: we=%b be=%b clr=%b err=%b done=%b off=%0d want all 0",
                     a_bank_we, a_bank_be, a_bank_clr, a_err, a_done, a_offset);
        else n_pass++;
        n_checks++;
        if ({b_bank_we, b_bank_be, b_bank_clr, b_done, b_offset} !== 34'b0)
            $display("FAIL reset_outs_b: we=%b be=%b clr=%b off=%0d want all 0",
                     b_bank_we, b_bank_be, b_bank_clr, b_offset);
        else n_pass++;
        n_checks++;
        if ({a_busy, a_instr_ready, b_busy, b_instr_ready} !== 4'b1010)
            $display("FAIL reset_busy: got %b want 1010", {a_busy, a_instr_ready, b_busy, b_instr_ready});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (a_bank_clr !== 4'hF || b_bank_clr !== 8'hFF)
            $display("FAIL reset_clr_all: a=%b b=%b want 1111/11111111", a_bank_clr, b_bank_clr);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (a_bank_clr !== 4'h0 || b_bank_clr !== 8'h00)
            $display("FAIL reset_clr_once: a=%b b=%b want 0", a_bank_clr, b_bank_clr);
        else n_pass++;
        n_checks++;
        if ({a_instr_ready, a_busy, b_instr_ready, b_busy} !== 4'b1010 || a_offset !== 9'd0)
            $display("FAIL reset_idle: rdy/busy=%b off=%0d want 1010/0",
                     {a_instr_ready, a_busy, b_instr_ready, b_busy}, a_offset);
        else n_pass++;
    endtask

    task automatic test_load(input logic [1:0] d, input bit rnd);
        int   acc;
        int   pulses;
        int   cyc;
        logic v;
        logic exp_done;
        logic [3:0] exp_be;
        acc = 0; pulses = 0; cyc = 0;
        send_a(c_load, 2'($urandom), d);
        while (acc < BEATS) begin
            v = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 2) == 0);
            a_beat_in_valid = v;
            #1;
            exp_be   = v ? 4'(1 << d) : 4'b0;
            exp_done = v && (acc == BEATS - 1);
            n_checks++;
            if (a_offset !== 9'(acc * XFER)) $display("FAIL load_offset beat %0d: got %0d want %0d", acc, a_offset, acc * XFER);
            else n_pass++;
            n_checks++;
            if (a_bank_be !== exp_be) $display("FAIL load_be beat %0d: got %b want %b", acc, a_bank_be, exp_be);
            else n_pass++;
            n_checks++;
            if ({a_bank_we, a_bank_clr} !== 8'b0) $display("FAIL load_other_strobes: we=%b clr=%b want 0", a_bank_we, a_bank_clr);
            else n_pass++;
            n_checks++;
            if (a_done !== exp_done || a_busy !== 1'b1)
                $display("FAIL load_done beat %0d: done=%b busy=%b want %b/1", acc, a_done, a_busy, exp_done);
            else n_pass++;
            if (a_bank_be != 4'b0) pulses++;
            if (v) acc++;
            cyc++;
            @(negedge clk);
        end
        a_beat_in_valid = 1'b1;
        #1;
        n_checks++;
        if (a_instr_ready !== 1'b1 || a_bank_be !== 4'b0 || a_offset !== 9'd0)
            $display("FAIL load_end: ready=%b be=%b off=%0d want 1/0000/0", a_instr_ready, a_bank_be, a_offset);
        else n_pass++;
        n_checks++;
        if (pulses != BEATS) $display("FAIL load_pulses: got %0d want %0d", pulses, BEATS);
        else n_pass++;
        a_beat_in_valid = 1'b0;
    endtask

    task automatic test_unload(input logic [1:0] s);
        int   xf;
        int   stall;
        logic r;
        logic exp_done;
        xf = 0; stall = 0;
        send_a(c_unload, s, 2'($urandom));
        while (xf < BEATS) begin
            if (xf == 20 && stall < 5) begin
                r = 1'b0;
                stall++;
            end else begin
                r = ($urandom_range(0, 3) != 0);
            end
            a_beat_out_ready = r;
            #1;
            exp_done = r && (xf == BEATS - 1);
            n_checks++;
            if (a_beat_out_valid !== 1'b1 || a_src_sel !== s)
                $display("FAIL unload_valid beat %0d: valid=%b src=%0d want 1/%0d", xf, a_beat_out_valid, a_src_sel, s);
            else n_pass++;
            n_checks++;
            if (a_offset !== 9'(xf * XFER)) $display("FAIL unload_offset beat %0d: got %0d want %0d", xf, a_offset, xf * XFER);
            else n_pass++;
            n_checks++;
            if (a_done !== exp_done) $display("FAIL unload_done beat %0d: got %b want %b", xf, a_done, exp_done);
            else n_pass++;
            n_checks++;
            if ({a_bank_we, a_bank_be, a_bank_clr} !== 12'b0) $display("FAIL unload_strobes: got %b want 0", {a_bank_we, a_bank_be, a_bank_clr});
            else n_pass++;
            if (r) xf++;
            @(negedge clk);
        end
        a_beat_out_ready = 1'b0;
        #1;
        n_checks++;
        if (a_instr_ready !== 1'b1 || a_beat_out_valid !== 1'b0)
            $display("FAIL unload_end: ready=%b valid=%b want 1/0", a_instr_ready, a_beat_out_valid);
        else n_pass++;
    endtask

    task automatic test_alu_ops();
        logic [3:0] op;
        logic [1:0] d;
        logic [1:0] last_alu;
        last_alu = 2'b00;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       op = c_add;
                1:       op = c_shift;
                2:       op = c_sub;
                default: op = c_mult;
            endcase
            d = 2'($urandom);
            send_a(op, 2'($urandom), d);
            #1;
            n_checks++;
            if (a_alu_sel !== exp_alu(op) || a_dst_sel !== d)
                $display("FAIL alu_sel op %b: alu=%b dst=%0d want %b/%0d", op, a_alu_sel, a_dst_sel, exp_alu(op), d);
            else n_pass++;
            n_checks++;
            if (a_bank_we !== 4'(1 << d) || a_done !== 1'b1)
                $display("FAIL alu_we op %b: we=%b done=%b want %b/1", op, a_bank_we, a_done, 4'(1 << d));
            else n_pass++;
            last_alu = exp_alu(op);
            @(negedge clk); #1;
            n_checks++;
            if (a_bank_we !== 4'b0 || a_done !== 1'b0 || a_instr_ready !== 1'b1)
                $display("FAIL alu_after: we=%b done=%b ready=%b want 0/0/1", a_bank_we, a_done, a_instr_ready);
            else n_pass++;
        end
        // alu_sel must survive a non-ALU instruction
        send_a(c_clear, 2'($urandom), 2'($urandom));
        #1;
        n_checks++;
        if (a_alu_sel !== last_alu) $display("FAIL alu_hold: got %b want %b", a_alu_sel, last_alu);
        else n_pass++;
    endtask

    task automatic test_exec_latency();
        logic [7:0] exp_we;
        send_b(c_mult, 3'd0, 3'd3);
        for (int k = 0; k < 3; k++) begin
            b_instr = 10'($urandom);
            #1;
            exp_we = (k == 2) ? 8'b0000_1000 : 8'b0;
            n_checks++;
            if (b_bank_we !== exp_we || b_done !== (k == 2))
                $display("FAIL exec_we cycle %0d: we=%b done=%b want %b/%b", k, b_bank_we, b_done, exp_we, (k == 2));
            else n_pass++;
            n_checks++;
            if (b_alu_sel !== 2'b11 || b_dst_sel !== 3'd3 || b_src_sel !== 3'd0 || b_busy !== 1'b1)
                $display("FAIL exec_hold cycle %0d: alu=%b dst=%0d src=%0d busy=%b want 11/3/0/1",
                         k, b_alu_sel, b_dst_sel, b_src_sel, b_busy);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (b_instr_ready !== 1'b1 || b_bank_we !== 8'b0 || b_alu_sel !== 2'b11)
            $display("FAIL exec_end: ready=%b we=%b alu=%b want 1/0/11", b_instr_ready, b_bank_we, b_alu_sel);
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [3:0] bad [7];
        bad = '{4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        for (int i = 0; i < 7; i++) begin
            send_a(bad[i], 2'($urandom), 2'($urandom));
            #1;
            n_checks++;
            if (a_err !== 1'b1 || a_instr_ready !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0)
                $display("FAIL invalid_err op %b: err=%b ready=%b busy=%b done=%b want 1/1/0/0",
                         bad[i], a_err, a_instr_ready, a_busy, a_done);
            else n_pass++;
            n_checks++;
            if ({a_bank_we, a_bank_be, a_bank_clr} !== 12'b0)
                $display("FAIL invalid_strobes op %b: got %b want 0", bad[i], {a_bank_we, a_bank_be, a_bank_clr});
            else n_pass++;
            @(negedge clk); #1;
            n_checks++;
            if (a_err !== 1'b0) $display("FAIL invalid_pulse op %b: err=%b want 0", bad[i], a_err);
            else n_pass++;
        end
        send_a(c_nop, 2'($urandom), 2'($urandom));
        #1;
        n_checks++;
        if (a_err !== 1'b0 || a_done !== 1'b0 || a_instr_ready !== 1'b1)
            $display("FAIL nop: err=%b done=%b ready=%b want 0/0/1", a_err, a_done, a_instr_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        logic [1:0] d;
        d = 2'($urandom);
        send_a(c_load, 2'($urandom), d);
        for (int i = 0; i < 10; i++) begin
            a_beat_in_valid = 1'b1;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (a_offset !== 9'd80) $display("FAIL midload_offset: got %0d want 80", a_offset);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_bank_we, a_bank_be, a_bank_clr} !== 12'b0 || a_done !== 1'b0 || a_offset !== 9'd0)
            $display("FAIL midload_abort: strobes=%b done=%b off=%0d want 0/0/0",
                     {a_bank_we, a_bank_be, a_bank_clr}, a_done, a_offset);
        else n_pass++;
        n_checks++;
        if ({a_busy, a_instr_ready} !== 2'b10) $display("FAIL midload_busy: got %b want 10", {a_busy, a_instr_ready});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (a_bank_clr !== 4'hF || a_bank_be !== 4'h0)
            $display("FAIL midload_clr: clr=%b be=%b want 1111/0000", a_bank_clr, a_bank_be);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (a_instr_ready !== 1'b1 || a_offset !== 9'd0 || a_bank_clr !== 4'h0 || a_bank_be !== 4'h0)
            $display("FAIL midload_idle: ready=%b off=%0d clr=%b be=%b want 1/0/0/0",
                     a_instr_ready, a_offset, a_bank_clr, a_bank_be);
        else n_pass++;
        a_beat_in_valid = 1'b0;
    endtask

    task automatic test_copy_clear();
        logic [1:0] s;
        logic [1:0] d;
        bit         is_copy;
        send_b(c_clear, 3'($urandom), 3'd5);
        #1;
        n_checks++;
        if (b_bank_clr !== 8'b0010_0000 || b_done !== 1'b1 || b_bank_we !== 8'b0)
            $display("FAIL clear_b: clr=%b done=%b we=%b want 00100000/1/0", b_bank_clr, b_done, b_bank_we);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (b_bank_clr !== 8'b0 || b_instr_ready !== 1'b1)
            $display("FAIL clear_b_once: clr=%b ready=%b want 0/1", b_bank_clr, b_instr_ready);
        else n_pass++;
        send_b(c_copy, 3'd7, 3'd0);
        #1;
        n_checks++;
        if (b_bank_we !== 8'b0000_0001 || b_bram_in_sel !== 1'b1 || b_src_sel !== 3'd7 || b_done !== 1'b1)
            $display("FAIL copy_b: we=%b bram=%b src=%0d done=%b want 00000001/1/7/1",
                     b_bank_we, b_bram_in_sel, b_src_sel, b_done);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (b_bank_we !== 8'b0 || b_bram_in_sel !== 1'b0)
            $display("FAIL copy_b_once: we=%b bram=%b want 0/0", b_bank_we, b_bram_in_sel);
        else n_pass++;
        // Random back-to-back COPY/CLEAR on instance A, src==dst allowed
        for (int i = 0; i < 10; i++) begin
            is_copy = 1'($urandom_range(0, 1));
            s = 2'($urandom);
            d = (i == 0) ? s : 2'($urandom);
            send_a(is_copy ? c_copy : c_clear, s, d);
            #1;
            n_checks++;
            if (a_bank_we !== (is_copy ? 4'(1 << d) : 4'b0) || a_bank_clr !== (is_copy ? 4'b0 : 4'(1 << d)) ||
                a_bram_in_sel !== is_copy || a_done !== 1'b1 || a_src_sel !== s)
                $display("FAIL copy_clear_a %0d: we=%b clr=%b bram=%b done=%b src=%0d (copy=%0d s=%0d d=%0d)",
                         i, a_bank_we, a_bank_clr, a_bram_in_sel, a_done, a_src_sel, is_copy, s, d);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load(2'd2, 1'b0);
        test_load(2'($urandom), 1'b1);
        test_unload(2'd1);
        test_alu_ops();
        test_exec_latency();
        test_invalid();
        test_copy_clear();
        test_reset_midload();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpu_ctrl_fsm.md
Name: mpu_ctrl_fsm

Overview:
Parametrised instruction sequencer for the matrix processing unit. It accepts host instructions through a valid/ready handshake and decodes them. It drives the BRAM bank write, beat-write and clear strobes, the source and destination bank selects, the ALU output select and the host transfer offset. It is a generalisation of the 4-bank controller: bank count, row width, transfer width and ALU latency are all parameters, and it adds beat-level flow control, operand latching, error reporting and a done pulse.

Parameters:
NUM_BANKS, 4, number of BRAM banks; must be a power of 2 and at least 2
DATA_BITS, 512, bits per bank row
XFER_BITS, 8, bits per host beat; must divide DATA_BITS
OP_LAT, 1, cycles from ALU operation start to a valid result; at least 1
Derived constants: BANK_W=clog2(NUM_BANKS), BEATS=DATA_BITS/XFER_BITS, OFF_W=clog2(DATA_BITS), INSTR_W=4+2*BANK_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
instr  in  INSTR_W  instruction: [3:0] opcode, [4+:BANK_W] src, [4+BANK_W+:BANK_W] dst
instr_valid  in  1  instr is presented
instr_ready  out  1  high only in IDLE
busy  out  1  high when state is not IDLE
err  out  1  one-cycle pulse on an invalid opcode
done  out  1  high in the final active cycle of an operation
src_sel  out  BANK_W  latched source bank
dst_sel  out  BANK_W  latched destination bank
alu_sel  out  2  00 add, 01 shift, 10 sub, 11 mult
bram_in_sel  out  1  1 selects BRAM-to-BRAM write data (COPY only)
bank_we  out  NUM_BANKS  full-row write strobe, one-hot
bank_be  out  NUM_BANKS  single-beat write strobe, one-hot
bank_clr  out  NUM_BANKS  bank clear strobe
offset  out  OFF_W  bit offset of the current beat
beat_in_valid  in  1  host write beat valid (LOAD)
beat_out_valid  out  1  read beat valid (UNLOAD)
beat_out_ready  in  1  host accepts the read beat

Behaviour:
- Opcodes: 0000 NOP, 0100 LOAD, 0110 UNLOAD, 0101 COPY, 0111 CLEAR, 1100 ADD, 1101 SHIFT, 1110 SUB, 1111 MULT. All other codes are invalid.
- Reset (asynchronous):
  - State goes to RESET.
  - All strobes, err, done, beat_out_valid, src_sel, dst_sel, alu_sel, offset and bram_in_sel are 0.
  - busy=1, instr_ready=0.
  - An operation in progress aborts with no further strobes.
- RESET state: bank_clr is all ones for 1 cycle, then the FSM goes to IDLE.
- IDLE:
  - An instruction is accepted at the edge where instr_valid and instr_ready are both high.
  - src, dst and the opcode are latched at acceptance. Later changes on instr are ignored.
  - The target state is active from the next cycle.
  - NOP is accepted and the FSM stays in IDLE with no done.
  - An invalid opcode is accepted, err pulses in the next cycle, and the FSM stays in IDLE.
- LOAD:
  - bank_be[dst] = beat_in_valid (combinational qualify).
  - offset = beat_cnt*XFER_BITS, starting at 0.
  - beat_cnt increments on each valid beat. Cycles with beat_in_valid low stall, holding offset.
  - On the BEATS-th accepted beat: done=1, then the FSM goes to IDLE.
- UNLOAD:
  - beat_out_valid=1 and src_sel=src.
  - A beat transfers when beat_out_ready=1.
  - Backpressure holds offset and beat_cnt.
  - On the BEATS-th transfer: done=1, then the FSM goes to IDLE.
- COPY: one cycle with bank_we[dst]=1, bram_in_sel=1 and done=1. src==dst is legal.
- CLEAR: one cycle with bank_clr[dst]=1 and done=1.
- ADD/SHIFT/SUB/MULT (EXEC state):
  - alu_sel is set at acceptance and held until the next ALU instruction.
  - EXEC lasts exactly OP_LAT cycles.
  - bank_we[dst] and done are high only in the last EXEC cycle.
- Strobe rules: at most one bank strobe bit is high per cycle, except in RESET. Strobes are 0 in IDLE.
- beat_cnt is clog2(BEATS)+1 bits wide. It is cleared on entry to LOAD or UNLOAD and never wraps within an operation.
- An unknown state encoding returns to RESET.

Decomposition:
- Package mpu_pkg holds:
  - opcode constants
  - alu_sel codes
  - FSM state encoding (RESET, IDLE, LOAD, UNLOAD, COPY, CLEAR, EXEC)
  - clog2 function
- Sub-module mpu_xfer_cnt holds the beat counter and offset generator, with inputs clr and inc and outputs offset and last.
- The EXEC latency counter stays inline.

Test Plan:
- Defaults. LOAD with dst=2; beat_in_valid alternates 1/0 -> exactly 64 bank_be=0100 pulses; offsets 0,8,…,504; done on the 64th beat; instr_ready=1 in the following cycle.
- UNLOAD with src=1; beat_out_ready low for 5 cycles at beat 20 -> offset holds 160 for those cycles; exactly 64 transfers; src_sel=1 throughout.
- OP_LAT=3. MULT src=0 dst=3; instr changes during EXEC -> alu_sel=11; bank_we=1000 only in the 3rd EXEC cycle; dst and alu_sel stay unchanged.
- Invalid opcode 0001 -> err high for 1 cycle; no strobes; instr_ready stays 1; busy=0.
- Reset asserted after 10 LOAD beats -> strobes drop immediately; bank_clr=1111 for 1 cycle after release; then instr_ready=1 and offset=0.
- NUM_BANKS=8. CLEAR dst=5 -> bank_clr=00100000 for 1 cycle. COPY src=7 dst=0 -> bank_we=00000001, bram_in_sel=1, src_sel=7, done=1.
